// File: rtl/la_clkdiv.sv
// Programmable glitch-free integer clock divider: clkout = clk / (divcfg + 2),
// with period-aligned run/stop, ratio latching and clk-domain edge strobes.
module la_clkdiv #(
  parameter int WIDTH = 8,
  parameter     PROP  = "DEFAULT"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] divcfg,
  output logic             clkout,
  output logic             rise,
  output logic             fall,
  output logic             active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // hi_len - 1 = ((N + 1) >> 1) - 1 = (divcfg + 1) >> 1; never exceeds WIDTH bits
  function automatic logic [WIDTH-1:0] hi_m1(input logic [WIDTH-1:0] cfg);
    return WIDTH'(({1'b0, cfg} + (WIDTH+1)'(1)) >> 1'b1);
  endfunction

  // lo_len - 1 = (N >> 1) - 1 = (N - 2) >> 1, from the latched ratio
  function automatic logic [WIDTH-1:0] lo_m1(input logic [WIDTH:0] n);
    return WIDTH'((n - (WIDTH+1)'(2)) >> 1'b1);
  endfunction

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] cnt_r, cnt_nxt_s;
  logic [WIDTH:0]   ratio_r, ratio_nxt_s;
  logic [WIDTH:0]   cfg_ratio_s;
  logic             rise_nxt_s, fall_nxt_s;
  logic             clkout_r, rise_r, fall_r, active_r;

  assign cfg_ratio_s = {1'b0, divcfg} + (WIDTH+1)'(2);

  // Next-state, counter and strobe decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ratio_nxt_s = ratio_r;
    rise_nxt_s  = 1'b0;
    fall_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_nxt_s = HIGH;
          ratio_nxt_s = cfg_ratio_s;
          cnt_nxt_s   = hi_m1(divcfg);
          rise_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HIGH: begin
        if (cnt_r != {WIDTH{1'b0}}) begin
          cnt_nxt_s = cnt_r - WIDTH'(1);
        end else begin
          state_nxt_s = LOW;
          cnt_nxt_s   = lo_m1(ratio_r);
          fall_nxt_s  = 1'b1;
        end
      end
      LOW: begin
        if (cnt_r != {WIDTH{1'b0}}) begin
          cnt_nxt_s = cnt_r - WIDTH'(1);
        end else if (en) begin
          // back-to-back period: relatch the ratio with no gap cycle
          state_nxt_s = HIGH;
          ratio_nxt_s = cfg_ratio_s;
          cnt_nxt_s   = hi_m1(divcfg);
          rise_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = {WIDTH{1'b0}};
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {WIDTH{1'b0}};
      end
    endcase
  end

  // State, shadow ratio and flop-driven outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {WIDTH{1'b0}};
      ratio_r  <= (WIDTH+1)'(2);
      clkout_r <= 1'b0;
      rise_r   <= 1'b0;
      fall_r   <= 1'b0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      ratio_r  <= ratio_nxt_s;
      clkout_r <= (state_nxt_s == HIGH);
      rise_r   <= rise_nxt_s;
      fall_r   <= fall_nxt_s;
      active_r <= (state_nxt_s != IDLE);
    end
  end

  assign clkout = clkout_r;
  assign rise   = rise_r;
  assign fall   = fall_r;
  assign active = active_r;

endmodule

// File: tb/tb_la_clkdiv.sv
// Table-driven bench for la_clkdiv: each row gives inputs for one clk edge and
// the outputs expected after it; expectations flow through a scoreboard queue.
module tb_la_clkdiv;

  localparam int W = 8;

  typedef struct {
    logic         rst;
    logic         en;
    logic [W-1:0] div;
    logic         clkout;
    logic         rise;
    logic         fall;
    logic         active;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] divcfg;
  logic         clkout, rise, fall, active;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   row      = 0;

  la_clkdiv #(.WIDTH(W), .PROP("DEFAULT")) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .divcfg (divcfg),
    .clkout (clkout),
    .rise   (rise),
    .fall   (fall),
    .active (active)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic e, input logic [W-1:0] d,
                              input logic c, input logic ri, input logic f, input logic a);
    vec_t v;
    v.rst = r; v.en = e; v.div = d;
    v.clkout = c; v.rise = ri; v.fall = f; v.active = a;
    return v;
  endfunction

  task automatic add(input logic r, input logic e, input logic [W-1:0] d,
                     input logic c, input logic ri, input logic f, input logic a);
    tbl.push_back(mk(r, e, d, c, ri, f, a));
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset  = v.rst;
    en     = v.en;
    divcfg = v.div;
    sb.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d t=%0t got=%b expected=%b", name, idx, $time, act, exp);
    end
  endtask

  // Compare DUT outputs against the oldest pending expectation, 1 time unit after the edge
  always @(posedge clk) begin
    vec_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("clkout", row, clkout, e.clkout);
      chk("rise",   row, rise,   e.rise);
      chk("fall",   row, fall,   e.fall);
      chk("active", row, active, e.active);
      row++;
    end
  end

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    divcfg = 8'd2;

    // reset held with en=1, then N=4 running
    for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 2; p++) begin
      add(1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1);
      add(1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      add(1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    // N=3: 1,1,0 twice
    for (int p = 0; p < 2; p++) begin
      add(1'b0, 1'b1, 8'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      add(1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1);
      add(1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    // N=2: 1,0 twice
    for (int p = 0; p < 2; p++) begin
      add(1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      add(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    // N=4 with en dropped in HIGH: period completes, then IDLE
    add(1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    // restart: clkout high one edge after en
    add(1'b0, 1'b1, 8'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // N=6 running, divcfg changed to 0 during HIGH: 3/3 then 1/1
    apply(mk(1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1));
    apply(mk(1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    apply(mk(1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1));
    apply(mk(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    apply(mk(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    apply(mk(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    apply(mk(1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 1'b0, 1'b1));
    apply(mk(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1));
    apply(mk(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0));

    // maximum ratio: 129 high, 128 low, then stop
    apply(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 128; i++) apply(mk(1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1));
    apply(mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1));
    for (int i = 0; i < 127; i++) apply(mk(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1));
    apply(mk(1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0));

    // reset in the 2nd high cycle of N=6: immediate truncation, stays IDLE
    apply(mk(1'b0, 1'b1, 8'd4, 1'b1, 1'b1, 1'b0, 1'b1));
    apply(mk(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1));
    apply(mk(1'b1, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    apply(mk(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0));
    apply(mk(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0));

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
